ccff_stream_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the logical tile `ccff_head` input. It accepts bitstream words over a valid/ready stream, serializes them LSB-first onto `ccff_head`, and gates `config_enable` so the chain shifts only when a bit is actually presented. A marker preamble shifted ahead of the payload comes back out of `ccff_tail` during the final shifts, which self-checks chain length and continuity.

---
 rtl/ccff_stream_loader.sv | 166 ++++++++++++++++
 tb/tb_ccff_stream_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: serializes bitstream words LSB-first onto the
// configuration chain head, preceded by a marker preamble. The marker comes
// back out of ccff_tail during the final shifts and is compared bit by bit,
// which checks chain length and continuity.
module ccff_stream_loader #(
  parameter int                  CHAIN_LEN = 64,
  parameter int                  WORD_W    = 8,
  parameter int                  MARKER_W  = 8,
  parameter logic [MARKER_W-1:0] MARKER    = 8'hA5
) (
  input  logic              prog_clock,
  input  logic              global_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              config_enable,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOT = CHAIN_LEN + MARKER_W;
  localparam int CW  = $clog2(TOT + 1);
  localparam int PW  = $clog2(CHAIN_LEN + 1);
  localparam int RW  = $clog2(WORD_W + 1);
  localparam int MW  = $clog2(MARKER_W + 1);

  typedef enum logic [1:0] {IDLE, MARK, DATA, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;     // shift edges seen this load
  logic [MW-1:0]     mi_q, mi_d;       // marker bit currently presented
  logic [PW-1:0]     prem_q, prem_d;   // payload bits still to present
  logic [RW-1:0]     rem_q, rem_d;     // buffered bits still to present
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              err_q, err_d;

  logic mark_last;
  logic feed;
  logic ready;
  logic accept;

  function automatic logic marker_bit(input logic [CW-1:0] idx);
    return |(MARKER & (MARKER_W'(1) << idx));
  endfunction

  // Next-state, serializer and marker self-check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mi_d    = mi_q;
    prem_d  = prem_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    head_d  = head_q;
    en_d    = 1'b0;
    err_d   = err_q;

    mark_last = (state_q == MARK) && (mi_q == MW'(MARKER_W - 1));
    // The first word is requested while the last marker bit is on the head,
    // so payload follows the preamble without a bubble.
    feed   = mark_last || ((state_q == DATA) && (prem_q != '0));
    ready  = feed && (rem_q == '0);
    accept = ready && cfg_valid;

    if (en_q) begin
      cnt_d = cnt_q + CW'(1);
      if ((cnt_q >= CW'(CHAIN_LEN)) && (cnt_q < CW'(TOT)) &&
          (ccff_tail != marker_bit(cnt_q - CW'(CHAIN_LEN)))) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MARK;
          err_d   = 1'b0;
          cnt_d   = '0;
          mi_d    = '0;
          prem_d  = PW'(CHAIN_LEN);
          rem_d   = '0;
          head_d  = MARKER[0];
          en_d    = 1'b1;
        end
      end
      MARK: begin
        if (!mark_last) begin
          mi_d   = mi_q + MW'(1);
          head_d = marker_bit(CW'(mi_q) + CW'(1));
          en_d   = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (prem_q == '0) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (feed) begin
      if (rem_q != '0) begin
        head_d = buf_q[0];
        buf_d  = buf_q >> 1;
        rem_d  = rem_q - RW'(1);
        prem_d = prem_q - PW'(1);
        en_d   = 1'b1;
      end else if (accept) begin
        head_d = cfg_data[0];
        buf_d  = cfg_data >> 1;
        // Bits of the final word beyond the chain length are never presented.
        if (32'(prem_q) < 32'(WORD_W)) begin
          rem_d = RW'(prem_q - PW'(1));
        end else begin
          rem_d = RW'(WORD_W - 1);
        end
        prem_d = prem_q - PW'(1);
        en_d   = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge prog_clock) begin
    if (!global_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mi_q    <= '0;
      prem_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mi_q    <= mi_d;
      prem_q  <= prem_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready     = ready;
  assign config_enable = en_q;
  assign ccff_head     = head_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign error         = err_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: behavioural chain of configurable length on
// the head/tail pins, table of directed loads, randomized loads checked
// against a stream-level reference model, and reset / start-while-busy cases.
module tb_ccff_stream_loader;

  localparam int          CL  = 12;
  localparam int          WW  = 8;
  localparam int          MKW = 8;
  localparam logic [7:0]  MK  = 8'hA5;

  logic       prog_clock = 1'b0;
  logic       global_reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, config_enable, ccff_head, ccff_tail, busy, done, error;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] chain = '0;
  int          model_len = 12;

  ccff_stream_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (WW),
    .MARKER_W (MKW),
    .MARKER   (MK)
  ) dut (
    .prog_clock   (prog_clock),
    .global_reset (global_reset),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .config_enable(config_enable),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 prog_clock = ~prog_clock;

  // Configuration chain: flop 0 nearest the head, shifts only when enabled
  always @(posedge prog_clock) begin
    if (config_enable) chain <= {chain[14:0], ccff_head};
  end
  assign ccff_tail = chain[4'(model_len - 1)];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Stream-level reference: preamble then payload words LSB-first, truncated
  // to the chain length; tail at shift k carries stream bit k-mlen.
  function automatic void ref_model(input logic [7:0] w0, input logic [7:0] w1,
                                    input int g0, input int g1, input int mlen,
                                    output logic [11:0] pay, output bit err,
                                    output int lat);
    bit          s[MKW + CL];
    logic [15:0] words;
    logic [7:0]  mk;
    mk    = MK;
    words = {w1, w0};
    for (int k = 0; k < MKW; k++) s[k] = mk[k];
    for (int j = 0; j < CL; j++) s[MKW + j] = words[j];
    pay = words[11:0];
    err = 1'b0;
    for (int k = CL; k < CL + MKW; k++) begin
      if (k - mlen >= 0 && s[k - mlen] != mk[k - CL]) err = 1'b1;
    end
    lat = MKW + CL + 1 + g0 + g1;
  endfunction

  task automatic do_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                         input int g0, input int g1, input int mlen, input bit poke,
                         input logic [11:0] exp_pay, input bit chk_pay,
                         input bit exp_err, input int exp_lat);
    logic [7:0]  w[2];
    int          gap[2];
    int          wi = 0, gc = 0, n = 0, lat = -1, stalls = 0, hold_bad = 0, extra = 0;
    bit          seen[$];
    int          en_at[$];
    bit          rdy_at[$];
    logic        prev_head;
    logic        err_at_done = 1'bx;
    logic [19:0] exp_s;
    logic [19:0] got_s = '0;
    logic [11:0] got_chain;

    w[0] = w0; w[1] = w1; gap[0] = g0; gap[1] = g1;
    exp_s = {exp_pay, MK};
    model_len = mlen;

    @(negedge prog_clock); start = 1'b1; cfg_valid = 1'b0;
    @(negedge prog_clock); start = 1'b0;
    n = 1;
    check({tag, " first_shift"}, {config_enable, ccff_head, busy, error},
          {1'b1, exp_s[0], 1'b1, 1'b0});
    prev_head = ccff_head;

    while (n < 200) begin
      if (done) begin
        lat = n;
        err_at_done = error;
        break;
      end
      if (config_enable) begin
        seen.push_back(ccff_head);
        en_at.push_back(n);
        rdy_at.push_back(cfg_ready);
      end else begin
        stalls++;
        if (ccff_head !== prev_head) hold_bad++;
      end
      prev_head = ccff_head;

      start = (poke && seen.size() == 3);
      if (cfg_ready && wi < 2) begin
        if (gc < gap[wi]) begin
          cfg_valid = 1'b0;
          gc++;
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = w[wi];
          wi++;
          gc = 0;
        end
      end else if (cfg_ready) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'($urandom);
        cfg_data  = 8'($urandom);
      end
      @(negedge prog_clock); n++;
    end

    cfg_valid = 1'b0;
    start = poke;
    @(negedge prog_clock); start = 1'b0;
    check({tag, " after_done"}, {done, busy, error}, {1'b0, 1'b0, exp_err});
    repeat (3) begin
      @(negedge prog_clock);
      if (done || busy) extra++;
    end
    check({tag, " no_restart"}, extra, 0);

    for (int i = 0; i < seen.size() && i < 20; i++) got_s[i] = seen[i];
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " en_cycles"}, seen.size(), MKW + CL);
    check({tag, " stream"}, got_s, exp_s);
    check({tag, " stalls"}, stalls, g0 + g1);
    check({tag, " stall_hold"}, hold_bad, 0);
    check({tag, " error_at_done"}, err_at_done, exp_err);
    if (g1 == 0 && en_at.size() > 16) begin
      check({tag, " refill_ready"}, rdy_at[15], 1'b1);
      check({tag, " refill_gapless"}, en_at[16] - en_at[15], 1);
    end
    if (chk_pay) begin
      for (int j = 0; j < CL; j++) got_chain[j] = chain[CL - 1 - j];
      check({tag, " chain"}, got_chain, exp_pay);
    end
  endtask

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          g0;
    int          g1;
    int          mlen;
    logic [11:0] pay;
    bit          chk;
    bit          err;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [11:0] r_pay;
    bit          r_err;
    int          r_lat;
    logic [7:0]  r_w0, r_w1;
    int          r_g0, r_g1, r_len;
    int          seen_done;

    tbl[0] = '{8'h3C, 8'h0F, 0, 0, 12, 12'hF3C, 1'b1, 1'b0, 21};
    tbl[1] = '{8'h3C, 8'h0F, 3, 3, 12, 12'hF3C, 1'b1, 1'b0, 27};
    tbl[2] = '{8'h3C, 8'h0F, 0, 0, 11, 12'hF3C, 1'b0, 1'b1, 21};
    tbl[3] = '{8'h3C, 8'h0F, 0, 0, 12, 12'hF3C, 1'b1, 1'b0, 21};
    tbl[4] = '{8'hA5, 8'hF6, 1, 0, 12, 12'h6A5, 1'b1, 1'b0, 22};
    tbl[5] = '{8'h00, 8'hFF, 0, 2, 12, 12'hF00, 1'b1, 1'b0, 23};

    repeat (3) @(negedge prog_clock);
    check("reset_outputs", {cfg_ready, config_enable, ccff_head, busy, done, error}, 6'b0);
    global_reset = 1'b1;
    @(negedge prog_clock);
    check("idle_outputs", {cfg_ready, config_enable, ccff_head, busy, done, error}, 6'b0);

    for (int i = 0; i < 6; i++) begin
      do_load($sformatf("vec%0d", i), tbl[i].w0, tbl[i].w1, tbl[i].g0, tbl[i].g1,
              tbl[i].mlen, (i == 3), tbl[i].pay, tbl[i].chk, tbl[i].err, tbl[i].lat);
    end

    // Reset in DATA on a short chain: error already raised, then cleared by reset
    model_len = 11;
    @(negedge prog_clock); start = 1'b1;
    @(negedge prog_clock); start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A;
    repeat (15) @(negedge prog_clock);
    check("pre_reset_busy_err", {busy, error}, 2'b11);
    global_reset = 1'b0;
    @(negedge prog_clock); global_reset = 1'b1; cfg_valid = 1'b0;
    check("midload_reset", {cfg_ready, config_enable, ccff_head, busy, done, error}, 6'b0);
    seen_done = 0;
    repeat (25) begin
      @(negedge prog_clock);
      if (done || busy || config_enable) seen_done++;
    end
    check("reset_abandons", seen_done, 0);
    do_load("post_reset", 8'h3C, 8'h0F, 0, 0, 12, 1'b0, 12'hF3C, 1'b1, 1'b0, 21);

    for (int r = 0; r < 10; r++) begin
      r_w0  = 8'($urandom);
      r_w1  = 8'($urandom);
      r_g0  = $urandom_range(0, 3);
      r_g1  = $urandom_range(0, 3);
      r_len = $urandom_range(11, 12);
      ref_model(r_w0, r_w1, r_g0, r_g1, r_len, r_pay, r_err, r_lat);
      do_load($sformatf("rnd%0d", r), r_w0, r_w1, r_g0, r_g1, r_len, (r % 3 == 0),
              r_pay, (r_len == 12), r_err, r_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
